mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback-select stage of the five-stage pipeline CPU. It captures the MEM-stage results and control on each rising CLK and drives the register file's write-side inputs directly. It also produces the resolved writeback value for forwarding to EX, and counts retired instructions. Write gating to register x0 happens here, so the register file never sees a write to x0.

---
 rtl/mem_wb_stage.sv | 136 +++++++++++++
 tb/tb_mem_wb_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures MEM results, gates writes to x0,
// resolves the writeback value for EX forwarding and counts retired instructions.
module mem_wb_stage #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             Stall,
   input  logic             Flush,
   input  logic             M_Valid,
   input  logic             M_RegWr,
   input  logic             M_immres,
   input  logic [1:0]       M_RegDst,
   input  logic [4:0]       M_WriteReg,
   input  logic [31:0]      M_AluOutput,
   input  logic [31:0]      M_Datain,
   input  logic [31:0]      M_extend,
   input  logic [31:0]      M_PC,
   input  logic [1:0]       M_cmp,
   output logic             W_Valid,
   output logic             W_RegWr,
   output logic             W_immres,
   output logic [1:0]       W_RegDst,
   output logic [4:0]       W_WriteReg,
   output logic [31:0]      W_AluOutput,
   output logic [31:0]      W_Datain,
   output logic [31:0]      W_extend,
   output logic [31:0]      W_PC,
   output logic [1:0]       W_cmp,
   output logic             FwdEn,
   output logic [31:0]      FwdData,
   output logic [CNT_W-1:0] RetireCnt
);

   logic             valid_q, valid_d;
   logic             regwr_q, regwr_d;
   logic             immres_q, immres_d;
   logic [1:0]       regdst_q, regdst_d;
   logic [4:0]       wreg_q, wreg_d;
   logic [31:0]      alu_q, alu_d;
   logic [31:0]      din_q, din_d;
   logic [31:0]      ext_q, ext_d;
   logic [31:0]      pc_q, pc_d;
   logic [1:0]       cmp_q, cmp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   // Flush only kills the slot; data fields keep their values so nothing toggles needlessly.
   always_comb begin
      valid_d  = valid_q;
      regwr_d  = regwr_q;
      immres_d = immres_q;
      regdst_d = regdst_q;
      wreg_d   = wreg_q;
      alu_d    = alu_q;
      din_d    = din_q;
      ext_d    = ext_q;
      pc_d     = pc_q;
      cmp_d    = cmp_q;
      if (Flush) begin
         valid_d = 1'b0;
         regwr_d = 1'b0;
      end else if (!Stall) begin
         valid_d  = M_Valid;
         regwr_d  = M_Valid & M_RegWr & (M_WriteReg != 5'd0);
         immres_d = M_immres;
         regdst_d = M_RegDst;
         wreg_d   = M_WriteReg;
         alu_d    = M_AluOutput;
         din_d    = M_Datain;
         ext_d    = M_extend;
         pc_d     = M_PC;
         cmp_d    = M_cmp;
      end
   end

   // The WB instruction leaves on any unstalled edge, flushed or not.
   assign retire = valid_q & ~Stall;
   assign cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, retire};

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         valid_q  <= 1'b0;
         regwr_q  <= 1'b0;
         immres_q <= 1'b0;
         regdst_q <= 2'd0;
         wreg_q   <= 5'd0;
         alu_q    <= 32'd0;
         din_q    <= 32'd0;
         ext_q    <= 32'd0;
         pc_q     <= 32'd0;
         cmp_q    <= 2'd0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         regwr_q  <= regwr_d;
         immres_q <= immres_d;
         regdst_q <= regdst_d;
         wreg_q   <= wreg_d;
         alu_q    <= alu_d;
         din_q    <= din_d;
         ext_q    <= ext_d;
         pc_q     <= pc_d;
         cmp_q    <= cmp_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      FwdData = alu_q;
      if (immres_q) begin
         FwdData = ext_q;
      end else begin
         unique case (regdst_q)
            2'b00:   FwdData = alu_q;
            2'b01:   FwdData = din_q;
            2'b10:   FwdData = pc_q + 32'd4;
            default: FwdData = {31'd0, cmp_q[0]};
         endcase
      end
   end

   assign FwdEn       = regwr_q;
   assign W_Valid     = valid_q;
   assign W_RegWr     = regwr_q;
   assign W_immres    = immres_q;
   assign W_RegDst    = regdst_q;
   assign W_WriteReg  = wreg_q;
   assign W_AluOutput = alu_q;
   assign W_Datain    = din_q;
   assign W_extend    = ext_q;
   assign W_PC        = pc_q;
   assign W_cmp       = cmp_q;
   assign RetireCnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for source select and gating,
// hand sequences for reset, stall/flush and counter wrap.
module tb_mem_wb_stage;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        Stall = 1'b0, Flush = 1'b0;
   logic        M_Valid = 1'b0, M_RegWr = 1'b0, M_immres = 1'b0;
   logic [1:0]  M_RegDst = 2'd0;
   logic [4:0]  M_WriteReg = 5'd0;
   logic [31:0] M_AluOutput = 32'd0, M_Datain = 32'd0, M_extend = 32'd0, M_PC = 32'd0;
   logic [1:0]  M_cmp = 2'd0;

   logic        W_Valid, W_RegWr, W_immres, FwdEn;
   logic [1:0]  W_RegDst, W_cmp;
   logic [4:0]  W_WriteReg;
   logic [31:0] W_AluOutput, W_Datain, W_extend, W_PC, FwdData, RetireCnt;

   logic        w_Valid, w_RegWr, w_immres, w_FwdEn;
   logic [1:0]  w_RegDst, w_cmp;
   logic [4:0]  w_WriteReg;
   logic [31:0] w_AluOutput, w_Datain, w_extend, w_PC, w_FwdData;
   logic [2:0]  cnt_w;

   always #5 CLK = ~CLK;

   mem_wb_stage #(.CNT_W(32)) dut (
      .CLK(CLK), .RST_n(RST_n), .Stall(Stall), .Flush(Flush),
      .M_Valid(M_Valid), .M_RegWr(M_RegWr), .M_immres(M_immres), .M_RegDst(M_RegDst),
      .M_WriteReg(M_WriteReg), .M_AluOutput(M_AluOutput), .M_Datain(M_Datain),
      .M_extend(M_extend), .M_PC(M_PC), .M_cmp(M_cmp),
      .W_Valid(W_Valid), .W_RegWr(W_RegWr), .W_immres(W_immres), .W_RegDst(W_RegDst),
      .W_WriteReg(W_WriteReg), .W_AluOutput(W_AluOutput), .W_Datain(W_Datain),
      .W_extend(W_extend), .W_PC(W_PC), .W_cmp(W_cmp),
      .FwdEn(FwdEn), .FwdData(FwdData), .RetireCnt(RetireCnt)
   );

   // Narrow-counter copy so the wrap from all-ones is reachable in a few cycles.
   mem_wb_stage #(.CNT_W(3)) dut_w (
      .CLK(CLK), .RST_n(RST_n), .Stall(Stall), .Flush(Flush),
      .M_Valid(M_Valid), .M_RegWr(M_RegWr), .M_immres(M_immres), .M_RegDst(M_RegDst),
      .M_WriteReg(M_WriteReg), .M_AluOutput(M_AluOutput), .M_Datain(M_Datain),
      .M_extend(M_extend), .M_PC(M_PC), .M_cmp(M_cmp),
      .W_Valid(w_Valid), .W_RegWr(w_RegWr), .W_immres(w_immres), .W_RegDst(w_RegDst),
      .W_WriteReg(w_WriteReg), .W_AluOutput(w_AluOutput), .W_Datain(w_Datain),
      .W_extend(w_extend), .W_PC(w_PC), .W_cmp(w_cmp),
      .FwdEn(w_FwdEn), .FwdData(w_FwdData), .RetireCnt(cnt_w)
   );

   typedef struct {
      logic        v, rw, imm;
      logic [1:0]  rd;
      logic [4:0]  wr;
      logic [31:0] alu, din, ext, pc;
      logic [1:0]  cmp;
      logic [31:0] efwd;
      logic        een;
   } vec_t;

   vec_t vec [10];
   int   n_chk = 0, n_fail = 0;
   int   exp_cnt = 0;
   logic m_valid = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " W_Valid"}, 64'(W_Valid), 64'd0);
      chk({tag, " W_RegWr"}, 64'(W_RegWr), 64'd0);
      chk({tag, " FwdEn"}, 64'(FwdEn), 64'd0);
      chk({tag, " FwdData"}, 64'(FwdData), 64'd0);
      chk({tag, " W_AluOutput"}, 64'(W_AluOutput), 64'd0);
      chk({tag, " W_WriteReg"}, 64'(W_WriteReg), 64'd0);
      chk({tag, " W_PC"}, 64'(W_PC), 64'd0);
      chk({tag, " RetireCnt"}, 64'(RetireCnt), 64'd0);
      chk({tag, " RetireCnt3"}, 64'(cnt_w), 64'd0);
   endtask

   // One clock edge with the reference model advanced alongside it.
   task automatic step();
      if (m_valid && !Stall) exp_cnt++;
      if (Flush) m_valid = 1'b0;
      else if (!Stall) m_valid = M_Valid;
      @(posedge CLK);
      #1;
      chk("RetireCnt", 64'(RetireCnt), 64'(exp_cnt));
      chk("RetireCnt3", 64'(cnt_w), 64'(exp_cnt % 8));
      chk("W_Valid model", 64'(W_Valid), 64'(m_valid));
   endtask

   task automatic drive(input vec_t t);
      M_Valid = t.v; M_RegWr = t.rw; M_immres = t.imm; M_RegDst = t.rd;
      M_WriteReg = t.wr; M_AluOutput = t.alu; M_Datain = t.din;
      M_extend = t.ext; M_PC = t.pc; M_cmp = t.cmp;
   endtask

   initial begin
      vec[0] = '{1'b1, 1'b1, 1'b0, 2'b00, 5'd5,  32'h11, 32'h22, 32'h33, 32'h100, 2'b01, 32'h11,  1'b1};
      vec[1] = '{1'b1, 1'b1, 1'b0, 2'b01, 5'd5,  32'h11, 32'h22, 32'h33, 32'h100, 2'b01, 32'h22,  1'b1};
      vec[2] = '{1'b1, 1'b1, 1'b0, 2'b10, 5'd5,  32'h11, 32'h22, 32'h33, 32'h100, 2'b01, 32'h104, 1'b1};
      vec[3] = '{1'b1, 1'b1, 1'b0, 2'b11, 5'd5,  32'h11, 32'h22, 32'h33, 32'h100, 2'b01, 32'h1,   1'b1};
      vec[4] = '{1'b1, 1'b1, 1'b1, 2'b10, 5'd5,  32'h11, 32'h22, 32'h33, 32'h100, 2'b01, 32'h33,  1'b1};
      vec[5] = '{1'b1, 1'b1, 1'b0, 2'b00, 5'd0,  32'h11, 32'h22, 32'h33, 32'h100, 2'b01, 32'h11,  1'b0};
      vec[6] = '{1'b1, 1'b1, 1'b0, 2'b10, 5'd7,  32'h11, 32'h22, 32'h33, 32'hFFFFFFFC, 2'b01, 32'h0, 1'b1};
      vec[7] = '{1'b0, 1'b1, 1'b0, 2'b01, 5'd3,  32'h44, 32'h55, 32'h66, 32'h200, 2'b00, 32'h55,  1'b0};
      vec[8] = '{1'b1, 1'b0, 1'b0, 2'b00, 5'd9,  32'h77, 32'h88, 32'h99, 32'h300, 2'b00, 32'h77,  1'b0};
      vec[9] = '{1'b1, 1'b1, 1'b0, 2'b11, 5'd31, 32'h1,  32'h2,  32'h3,  32'h400, 2'b10, 32'h0,   1'b1};

      // Reset with busy inputs and a running clock.
      M_Valid = 1'b1; M_RegWr = 1'b1; M_WriteReg = 5'd12; M_AluOutput = 32'hDEAD;
      M_PC = 32'h1234; M_RegDst = 2'b10;
      repeat (3) begin
         @(posedge CLK);
         #1;
         check_zero("reset");
      end
      @(negedge CLK);
      RST_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         drive(vec[i]);
         step();
         chk($sformatf("vec%0d FwdData", i), 64'(FwdData), 64'(vec[i].efwd));
         chk($sformatf("vec%0d FwdEn", i), 64'(FwdEn), 64'(vec[i].een));
         chk($sformatf("vec%0d W_RegWr", i), 64'(W_RegWr), 64'(vec[i].een));
         chk($sformatf("vec%0d W_WriteReg", i), 64'(W_WriteReg), 64'(vec[i].wr));
         chk($sformatf("vec%0d W_AluOutput", i), 64'(W_AluOutput), 64'(vec[i].alu));
      end

      // Instruction A, then three stalled edges with changing inputs.
      drive('{1'b1, 1'b1, 1'b0, 2'b00, 5'd6, 32'hAAAA, 32'h1, 32'h2, 32'h500, 2'b00, 32'h0, 1'b0});
      step();
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         M_AluOutput = 32'h1000 + 32'(i); M_WriteReg = 5'd20 + 5'(i); M_Valid = 1'b0;
         step();
         chk("stall W_AluOutput", 64'(W_AluOutput), 64'hAAAA);
         chk("stall W_WriteReg", 64'(W_WriteReg), 64'd6);
         chk("stall FwdEn", 64'(FwdEn), 64'd1);
      end
      Flush = 1'b1;
      step();
      chk("flush+stall W_RegWr", 64'(W_RegWr), 64'd0);
      chk("flush+stall FwdEn", 64'(FwdEn), 64'd0);
      chk("flush+stall W_AluOutput", 64'(W_AluOutput), 64'hAAAA);
      chk("flush+stall W_WriteReg", 64'(W_WriteReg), 64'd6);

      // Instruction B, then flush without stall: B still retires.
      Flush = 1'b0; Stall = 1'b0;
      drive('{1'b1, 1'b1, 1'b0, 2'b01, 5'd8, 32'hBBBB, 32'hCCCC, 32'h2, 32'h600, 2'b00, 32'h0, 1'b0});
      step();
      chk("B FwdData", 64'(FwdData), 64'hCCCC);
      Flush = 1'b1;
      step();
      chk("flush W_RegWr", 64'(W_RegWr), 64'd0);
      chk("flush W_Datain", 64'(W_Datain), 64'hCCCC);
      Flush = 1'b0;

      // Asynchronous reset while stalled, checked before any clock edge.
      drive('{1'b1, 1'b1, 1'b0, 2'b00, 5'd4, 32'h4444, 32'h1, 32'h2, 32'h700, 2'b00, 32'h0, 1'b0});
      step();
      Stall = 1'b1;
      #2;
      RST_n = 1'b0;
      #1;
      check_zero("async reset");
      exp_cnt = 0;
      m_valid = 1'b0;
      @(negedge CLK);
      RST_n = 1'b1;
      Stall = 1'b0;

      // Nine valid edges: eight retirements wrap the 3-bit counter to 0.
      drive('{1'b1, 1'b1, 1'b0, 2'b00, 5'd2, 32'h5, 32'h1, 32'h2, 32'h800, 2'b00, 32'h0, 1'b0});
      for (int i = 0; i < 8; i++) step();
      chk("cnt3 at all-ones", 64'(cnt_w), 64'd7);
      step();
      chk("cnt3 wrapped", 64'(cnt_w), 64'd0);
      chk("cnt32 after wrap", 64'(RetireCnt), 64'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
